// File: rtl/cu_pkg.sv
// Shared types and constants for the MSP430 format-I control sequencer.
package cu_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, READ, EXEC, WB, PCUP, HALT} state_t;

  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_ADDC = 4'h6;
  localparam logic [3:0] OP_SUBC = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_DADD = 4'hA;
  localparam logic [3:0] OP_BIT  = 4'hB;
  localparam logic [3:0] OP_BIC  = 4'hC;
  localparam logic [3:0] OP_BIS  = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_AND  = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int SRC_LSB = 8;
  localparam int AD_BIT  = 7;
  localparam int BW_BIT  = 6;
  localparam int AS_LSB  = 4;
  localparam int DST_LSB = 0;

  localparam logic [3:0] PC_REG = 4'h0;

endpackage

// File: rtl/cu_decode.sv
// Field extraction and legality check for register-mode double-operand instructions.
module cu_decode
  import cu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  src,
  output logic [3:0]  dst,
  output logic        bw,
  output logic        legal,
  output logic        writes_dst
);

  logic       ad;
  logic [1:0] as_mode;
  logic       fmt1;

  assign opcode  = ir[OPC_LSB +: 4];
  assign src     = ir[SRC_LSB +: 4];
  assign dst     = ir[DST_LSB +: 4];
  assign ad      = ir[AD_BIT];
  assign bw      = ir[BW_BIT];
  assign as_mode = ir[AS_LSB +: 2];

  assign fmt1 = opcode inside {OP_MOV, OP_ADD, OP_ADDC, OP_SUBC, OP_SUB, OP_CMP,
                               OP_DADD, OP_BIT, OP_BIC, OP_BIS, OP_XOR, OP_AND};

  // Only register-to-register addressing is supported.
  assign legal      = fmt1 && (as_mode == 2'b00) && !ad;
  assign writes_dst = !((opcode == OP_CMP) || (opcode == OP_BIT));

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the register bank and ALU.
module control_unit
  import cu_pkg::*;
#(
  parameter int ALU_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr_data,
  input  logic             instr_ready,
  output logic             instr_req,
  output logic [3:0]       src_reg,
  output logic [3:0]       dst_reg,
  output logic [3:0]       wr_reg,
  output logic             wr_en,
  output logic             pc_inc,
  output logic [3:0]       alu_op,
  output logic             alu_byte,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  state_t        state, next_state;
  logic [15:0]   ir;
  logic [TW-1:0] timer;
  logic [3:0]    d_op, d_src, d_dst;
  logic          d_bw, d_legal, d_writes;
  logic          fetch_hit, alu_wait, wait_expired;

  cu_decode u_dec (
    .ir        (ir),
    .opcode    (d_op),
    .src       (d_src),
    .dst       (d_dst),
    .bw        (d_bw),
    .legal     (d_legal),
    .writes_dst(d_writes)
  );

  assign fetch_hit    = (state == FETCH) && instr_req && instr_ready;
  // timer==0 is the start cycle; alu_done counts only from the cycle after.
  assign alu_wait     = (state == EXEC) && (timer != '0);
  assign wait_expired = alu_wait && !alu_done && (timer == TW'(ALU_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  if (fetch_hit) next_state = DECODE;
      DECODE: next_state = d_legal ? READ : HALT;
      READ:   next_state = EXEC;
      EXEC: begin
        if (alu_wait && alu_done) next_state = WB;
        else if (wait_expired)    next_state = HALT;
      end
      WB:     next_state = (d_writes && (dst_reg == PC_REG)) ? FETCH : PCUP;
      PCUP:   next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = HALT;
    endcase
  end

  always_comb begin
    alu_start = (state == EXEC) && (timer == '0);
    wr_en     = (state == WB) && d_writes;
    wr_reg    = wr_en ? dst_reg : 4'h0;
    pc_inc    = (state == PCUP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      instr_req <= 1'b0;
      src_reg   <= '0;
      dst_reg   <= '0;
      alu_op    <= '0;
      alu_byte  <= 1'b0;
      timer     <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
      retired   <= '0;
    end else begin
      // Registered so the request stays low for the whole reset cycle.
      instr_req <= (next_state == FETCH);
      if (fetch_hit) ir <= instr_data;
      if (state == DECODE) begin
        if (d_legal) begin
          src_reg  <= d_src;
          dst_reg  <= d_dst;
          alu_op   <= d_op;
          alu_byte <= d_bw;
        end else begin
          illegal <= 1'b1;
          halted  <= 1'b1;
        end
      end
      if (state == EXEC) timer <= timer + 1'b1;
      else               timer <= '0;
      if (wait_expired) begin
        timeout <= 1'b1;
        halted  <= 1'b1;
      end
      if (state == WB) retired <= retired + 1'b1;
    end
  end

endmodule
